// File: rtl/srl_fifo_flags.sv
// srl_fifo_flags: parametrised shift-register FIFO with first-word-fall-through
// output, used for line and pixel buffering in the 2D FIR datapath.
//
// The storage is a plain shift array with no reset and a single shift enable,
// so that it maps onto SRL primitives. Only the fill level and the flags are
// reset. The read port is a mux that selects the oldest entry using the level.
//
// Ports:
//   clk           rising-edge clock; the only clock domain
//   rst           synchronous reset, active-low
//   flush         synchronous clear of contents and level, active-high
//   wr, d         write request and write data
//   rd            read request; pops the word currently on q
//   q             oldest entry, combinational; not meaningful while empty
//   full          level == DEPTH
//   almost_full   level >= AF_LEVEL
//   empty         level == 0
//   almost_empty  level <= AE_LEVEL
//   level         current number of entries, 0..DEPTH
//   overflow      sticky: a write was rejected because the FIFO was full
//   underflow     sticky: a read was attempted while the FIFO was empty
module srl_fifo_flags #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter int unsigned LW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr,
   input  logic [WIDTH-1:0] d,
   output logic             full,
   output logic             almost_full,
   input  logic             rd,
   output logic [WIDTH-1:0] q,
   output logic             empty,
   output logic             almost_empty,
   output logic [LW-1:0]    level,
   output logic             overflow,
   output logic             underflow
);

   // Width of an index into the storage array.
   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
   localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);
   localparam logic [LW-1:0] ONE_L   = LW'(1);

   logic [WIDTH-1:0] mem [DEPTH];

   logic          op_en_c;
   logic          rd_acc_c;
   logic          wr_acc_c;
   logic          shift_en_c;
   logic [LW-1:0] level_nxt_c;
   logic [LW-1:0] rd_idx_c;

   // Accept rules and next fill level. A flush takes precedence over
   // requests, so requests in a flush cycle are neither accepted nor flagged.
   always_comb begin
      op_en_c     = rst & ~flush;
      rd_acc_c    = rd & ~empty;
      // A full FIFO still accepts a write when a read frees a slot in the same cycle.
      wr_acc_c    = wr & (~full | rd_acc_c);
      shift_en_c  = op_en_c & wr_acc_c;
      level_nxt_c = level;
      if (flush) begin
         level_nxt_c = '0;
      end else if (wr_acc_c && !rd_acc_c) begin
         level_nxt_c = level + ONE_L;
      end else if (rd_acc_c && !wr_acc_c) begin
         level_nxt_c = level - ONE_L;
      end
   end

   // Shift storage: the newest word enters at entry 0. There is deliberately
   // no reset and no flush here, so that the array maps onto SRL primitives.
   always_ff @(posedge clk) begin
      if (shift_en_c) begin
         mem[0] <= d;
         for (int i = 1; i < int'(DEPTH); i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   // The oldest entry sits at index level-1. The accept rules keep the level
   // at or below DEPTH, so the index stays inside the array. An empty FIFO
   // selects entry 0, which avoids an underflowed index.
   always_comb begin
      rd_idx_c = '0;
      if (level != '0) begin
         rd_idx_c = level - ONE_L;
      end
      q = mem[AW'(rd_idx_c)];
   end

   // The level and the flags are registered together. Each flag is computed
   // from the next level, so it always matches the level it is shown with.
   always_ff @(posedge clk) begin
      if (!rst) begin
         level        <= '0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         level        <= level_nxt_c;
         full         <= (level_nxt_c == DEPTH_L);
         almost_full  <= (level_nxt_c >= AF_L);
         empty        <= (level_nxt_c == '0);
         almost_empty <= (level_nxt_c <= AE_L);
         // The error bits are sticky. Only rst clears them, not a flush.
         if (!flush) begin
            if (wr && !wr_acc_c) begin
               overflow <= 1'b1;
            end
            if (rd && empty) begin
               underflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_srl_fifo_flags.sv
// Self-checking bench for srl_fifo_flags. One instance is a DEPTH=8 FIFO that
// runs the directed sequence. A second instance is a DEPTH=5 FIFO, a depth
// that is not a power of two, that runs random traffic against a count model.
// Stimulus pushes the expected read data into queues. Monitors pop a queue and
// compare q whenever a DUT accepts a read.
module tb_srl_fifo_flags;

   logic clk = 1'b0;
   logic rst;

   // DEPTH=8 instance
   logic       flush8, wr8, rd8;
   logic [7:0] d8, q8;
   logic       full8, af8, empty8, ae8, ovf8, unf8;
   logic [3:0] level8;

   // DEPTH=5 instance
   logic       flush5, wr5, rd5;
   logic [7:0] d5, q5;
   logic       full5, af5, empty5, ae5, ovf5, unf5;
   logic [2:0] level5;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp8[$];
   logic [7:0] exp5[$];

   always #5 clk = ~clk;

   srl_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_dut8 (
      .clk(clk), .rst(rst), .flush(flush8), .wr(wr8), .d(d8),
      .full(full8), .almost_full(af8), .rd(rd8), .q(q8),
      .empty(empty8), .almost_empty(ae8), .level(level8),
      .overflow(ovf8), .underflow(unf8)
   );

   srl_fifo_flags #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut5 (
      .clk(clk), .rst(rst), .flush(flush5), .wr(wr5), .d(d5),
      .full(full5), .almost_full(af5), .rd(rd5), .q(q5),
      .empty(empty5), .almost_empty(ae5), .level(level5),
      .overflow(ovf5), .underflow(unf5)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Flags are packed as {full, almost_full, empty, almost_empty, overflow, underflow}.
   function automatic logic [5:0] flags8();
      return {full8, af8, empty8, ae8, ovf8, unf8};
   endfunction

   function automatic logic [5:0] flags5();
      return {full5, af5, empty5, ae5, ovf5, unf5};
   endfunction

   function automatic logic [5:0] ef8(input int l, input logic o, input logic u);
      return {l == 8, l >= 6, l == 0, l <= 2, o, u};
   endfunction

   function automatic logic [5:0] ef5(input int l, input logic o, input logic u);
      return {l == 5, l >= 3, l == 0, l <= 1, o, u};
   endfunction

   // Drive the requests for the next edge, then settle 1 time unit past that edge.
   task automatic step8(input logic w, input logic r, input logic [7:0] dd);
      wr8 = w; rd8 = r; d8 = dd;
      @(posedge clk); #1;
   endtask

   task automatic step5(input logic w, input logic r, input logic [7:0] dd);
      wr5 = w; rd5 = r; d5 = dd;
      @(posedge clk); #1;
   endtask

   // Read-data monitors. They sample on the falling edge, when the requests
   // for the coming rising edge are already stable.
   always @(negedge clk) begin
      if (rst === 1'b1 && flush8 === 1'b0 && rd8 === 1'b1 && empty8 === 1'b0) begin
         if (exp8.size() == 0) begin
            chk("q8_unexpected_pop", 32'(q8), 32'hFFFF_FFFF);
         end else begin
            chk("q8_data", 32'(q8), 32'(exp8.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1 && flush5 === 1'b0 && rd5 === 1'b1 && empty5 === 1'b0) begin
         if (exp5.size() == 0) begin
            chk("q5_unexpected_pop", 32'(q5), 32'hFFFF_FFFF);
         end else begin
            chk("q5_data", 32'(q5), 32'(exp5.pop_front()));
         end
      end
   end

   initial begin
      int  m5;
      logic o5, u5, w, r, racc, wacc;
      logic [7:0] dd;

      rst = 1'b0;
      flush8 = 1'b0; wr8 = 1'b0; rd8 = 1'b0; d8 = '0;
      flush5 = 1'b0; wr5 = 1'b0; rd5 = 1'b0; d5 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level8", 32'(level8), 32'd0);
      chk("rst_flags8", 32'(flags8()), 32'(6'b001100));
      chk("rst_level5", 32'(level5), 32'd0);
      chk("rst_flags5", 32'(flags5()), 32'(6'b001100));
      rst = 1'b1;

      // Fill with 0x01..0x08.
      for (int i = 1; i <= 8; i++) begin
         exp8.push_back(8'(i));
         step8(1'b1, 1'b0, 8'(i));
         chk("fill_level", 32'(level8), 32'(i));
         chk("fill_flags", 32'(flags8()), 32'(ef8(i, 1'b0, 1'b0)));
      end

      // A write while full is rejected and sets overflow.
      step8(1'b1, 1'b0, 8'h55);
      chk("ovf_level", 32'(level8), 32'd8);
      chk("ovf_flags", 32'(flags8()), 32'(ef8(8, 1'b1, 1'b0)));

      // A write and a read on a full FIFO are both accepted. This pops 0x01..0x03.
      for (int k = 0; k < 3; k++) begin
         exp8.push_back(8'hAA);
         step8(1'b1, 1'b1, 8'hAA);
         chk("fullrw_level", 32'(level8), 32'd8);
         chk("fullrw_flags", 32'(flags8()), 32'(ef8(8, 1'b1, 1'b0)));
      end

      // Drain: 0x04..0x08 then 0xAA x3 come out, and 0x55 never does.
      for (int i = 7; i >= 0; i--) begin
         step8(1'b0, 1'b1, 8'h00);
         chk("drain_level", 32'(level8), 32'(i));
         chk("drain_flags", 32'(flags8()), 32'(ef8(i, 1'b1, 1'b0)));
      end

      // A write and a read on an empty FIFO: the write lands and underflow is set.
      exp8.push_back(8'h3C);
      step8(1'b1, 1'b1, 8'h3C);
      chk("emptyrw_level", 32'(level8), 32'd1);
      chk("emptyrw_flags", 32'(flags8()), 32'(ef8(1, 1'b1, 1'b1)));
      step8(1'b0, 1'b1, 8'h00);
      chk("emptyrw_pop_level", 32'(level8), 32'd0);

      // Reach level 5, then flush with wr and rd also asserted.
      for (int i = 0; i < 5; i++) begin
         step8(1'b1, 1'b0, 8'(8'h10 + 8'(i)));
      end
      chk("pre_flush_level", 32'(level8), 32'd5);
      flush8 = 1'b1;
      step8(1'b1, 1'b1, 8'hEE);
      flush8 = 1'b0;
      chk("flush_level", 32'(level8), 32'd0);
      chk("flush_flags", 32'(flags8()), 32'(ef8(0, 1'b1, 1'b1)));

      // After the flush, data falls through again.
      exp8.push_back(8'h77);
      step8(1'b1, 1'b0, 8'h77);
      chk("post_flush_level", 32'(level8), 32'd1);
      step8(1'b0, 1'b1, 8'h00);
      chk("post_flush_pop_level", 32'(level8), 32'd0);

      // Reset pulse clears the error bits.
      rst = 1'b0;
      step8(1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      chk("rst2_level8", 32'(level8), 32'd0);
      chk("rst2_flags8", 32'(flags8()), 32'(6'b001100));
      chk("exp8_drained", 32'(exp8.size()), 32'd0);

      // Random traffic on the DEPTH=5 instance against a fill-count model.
      m5 = 0; o5 = 1'b0; u5 = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         w    = 1'($urandom_range(0, 1));
         r    = 1'($urandom_range(0, 1));
         dd   = 8'($urandom);
         racc = r && (m5 > 0);
         wacc = w && ((m5 < 5) || racc);
         if (w && !wacc) o5 = 1'b1;
         if (r && (m5 == 0)) u5 = 1'b1;
         if (wacc) exp5.push_back(dd);
         if (wacc && !racc) m5++;
         else if (racc && !wacc) m5--;
         step5(w, r, dd);
         chk("rnd_level5", 32'(level5), 32'(m5));
         chk("rnd_flags5", 32'(flags5()), 32'(ef5(m5, o5, u5)));
      end
      wr5 = 1'b0; rd5 = 1'b0;
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/srl_fifo_flags.md
Name: srl_fifo_flags

Overview:
Parametrised successor to the team's shift-register FIFO, intended for line and pixel buffering in the 2D FIR datapath. Storage is an SRL-style shift array with a first-word-fall-through output. Adds the following over the previous block:
- DEPTH of any value ≥ 2 (not limited to powers of two)
- guarded writes and reads
- explicit fill level
- threshold flags
- sticky overflow/underflow error bits
- synchronous flush

Parameters:
WIDTH, 8, data word width in bits (≥ 1)
DEPTH, 32, number of entries (≥ 2, any integer)
AF_LEVEL, DEPTH-2, almost_full asserts when level ≥ AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when level ≤ AE_LEVEL (0..DEPTH-1)
LW, $clog2(DEPTH+1), level port width (derived; do not override)

Ports:
clk  input  1  rising-edge clock; sole clock domain
rst  input  1  synchronous reset, active-low (sampled on rising clk edge)
flush  input  1  synchronous clear of contents and level (active-high)
wr  input  1  write request
d  input  WIDTH  write data
full  output  1  level == DEPTH
almost_full  output  1  level ≥ AF_LEVEL
rd  input  1  read request (pops current q)
q  output  WIDTH  oldest entry (first-word-fall-through)
empty  output  1  level == 0
almost_empty  output  1  level ≤ AE_LEVEL
level  output  LW  current entry count, 0..DEPTH
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Priority per edge: rst low > flush > normal operation.
- Reset (rst==0):
  - level=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents immediately.
- flush=1 (rst high):
  - Same as reset for level and all flags.
  - overflow and underflow are NOT cleared by flush; only rst clears them.
  - wr/rd in the same cycle are ignored and do not set error bits.
- Accept rules:
  - wr_acc = wr & (~full | rd_acc)
  - rd_acc = rd & ~empty
  - Write and read on a full FIFO: both accepted, level unchanged.
  - Write and read on an empty FIFO: write accepted, read rejected, underflow set, level becomes 1.
- Storage:
  - On wr_acc, the array shifts: entry0 ← d, entry i ← entry i-1.
  - No other storage activity; the array never shifts without wr_acc.
- Level update:
  - +1 on wr_acc & ~rd_acc.
  - −1 on rd_acc & ~wr_acc.
  - Unchanged otherwise.
  - Never exceeds DEPTH and never goes below 0.
- Output q:
  - Combinational: q = entry[level-1] when level > 0.
  - q is unspecified when empty; the bench must not check it.
  - Fall-through latency: a word written at edge N is visible on q after edge N when the FIFO was empty, so it can be popped at edge N+1.
- Flags:
  - full, empty, almost_full, almost_empty are registered.
  - They are computed from the next level and update on the same edge as level, so they always equal their definition over the current level.
  - No combinational path from wr/rd to any flag.
- Error bits:
  - overflow is set on wr & ~wr_acc.
  - underflow is set on rd & empty.
  - Both stay set until rst.
  - Rejected requests change no other state.
- Read-address width:
  - Index arithmetic uses LW bits.
  - No wrap-around: level saturation by the accept rules guarantees the index stays in 0..DEPTH-1.
- Synthesis:
  - Storage must infer SRL primitives: no reset or flush on the array, and a single write-enable.

Test Plan:
- DEPTH=8, WIDTH=8, AF_LEVEL=6, AE_LEVEL=2. Release rst, then write 0x01..0x08 on consecutive cycles.
  -> level counts 1..8; almost_empty deasserts at level 3; almost_full asserts at level 6; full=1 at level 8; no error bits.
- From full, hold wr=1 with d=0x55 for one cycle, rd=0.
  -> overflow=1 sticky, level stays 8, then draining yields q sequence 0x01..0x08 (0x55 absent).
- Full FIFO, simultaneous wr=1 (d=0xAA) and rd=1 for 3 cycles.
  -> pops 0x01, 0x02, 0x03; level stays 8; full stays 1; a subsequent drain ends with 0xAA, 0xAA, 0xAA.
- Empty FIFO, wr=1 (d=0x3C) and rd=1 together.
  -> level=1, q=0x3C next cycle, underflow=1, empty=0.
- Level 5, assert flush with wr=1 and rd=1.
  -> next cycle level=0, empty=1, almost_empty=1, overflow/underflow unchanged.
  -> Then pulse rst low for 1 cycle -> all flags at reset values, errors cleared.
- DEPTH=5 (non-power-of-two), random wr/rd for 2000 cycles against a queue model.
  -> q matches the model on every accepted read; level never exceeds 5; flags consistent every cycle.
